// File: rtl/cim_pkg.sv
// Shared constants for the CIM MAC sequencer: default window base, register map
// and FSM state encoding.
package cim_pkg;

  localparam logic [31:0] CIM_BASE_DEF = 32'h0800_0000;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned OPND_W       = 16;
  localparam int unsigned REG_IDX_W    = 3;

  localparam logic [REG_IDX_W-1:0] REG_CTRL = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_SRCA = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_SRCB = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_LEN  = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_ACC  = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_CYC  = 3'd5;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_CLR_ACC  = 1;
  localparam int unsigned CTRL_CLR_DONE = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_ACC     = 3'd3,
    ST_FIN     = 3'd4
  } cim_state_e;

endpackage

// File: rtl/cim_mac_unit.sv
// Signed 16x16 multiply folded into a 32-bit wrap-around accumulator.
module cim_mac_unit
  import cim_pkg::*;
(
  input  logic [XLEN-1:0]   acc,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [XLEN-1:0]   sum_c
);

  logic signed [XLEN-1:0] a_ext_c;
  logic signed [XLEN-1:0] b_ext_c;
  logic signed [XLEN-1:0] prod_c;

  assign a_ext_c = {{(XLEN-OPND_W){a[OPND_W-1]}}, a};
  assign b_ext_c = {{(XLEN-OPND_W){b[OPND_W-1]}}, b};
  assign prod_c  = a_ext_c * b_ext_c;
  assign sum_c   = acc + $unsigned(prod_c);

endmodule

// File: rtl/cim_mac_seq.sv
// Memory-mapped MAC sequencer: fetches A[i], B[i] over the data-memory master port
// and accumulates their signed product; core traffic passes through while idle.
module cim_mac_seq
  import cim_pkg::*;
#(
  parameter logic [31:0] CIM_BASE = CIM_BASE_DEF,
  parameter int unsigned LEN_W    = 16
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] C_DADDR,
  input  logic [31:0] C_DATAO,
  input  logic [3:0]  C_BE,
  input  logic        C_WR,
  input  logic        C_RD,
  output logic [31:0] C_DATAI,
  output logic        C_HLT,
  output logic [31:0] M_DADDR,
  output logic [31:0] M_DATAO,
  output logic [3:0]  M_BE,
  output logic        M_WR,
  output logic        M_RD,
  input  logic [31:0] M_DATAI,
  output logic        DONE
);

  cim_state_e             state, state_nxt;
  logic [XLEN-1:0]        srca, srcb, acc, cyc;
  logic [LEN_W-1:0]       len, elem;
  logic [OPND_W-1:0]      a_q;
  logic                   done;
  logic [XLEN-1:0]        mac_sum_c;
  logic [XLEN-1:0]        rdata_c;
  logic                   hit_c, busy_c, wr_c, wr_ctrl_c;
  logic                   start_c, clr_acc_c, clr_done_c;
  logic [REG_IDX_W-1:0]   idx_c;
  logic [LEN_W-1:0]       elem_inc_c;

  // Word address aligned to the 8-register window
  assign hit_c      = (C_DADDR[31:3] == 29'(CIM_BASE[31:5]));
  assign idx_c      = C_DADDR[2:0];
  assign busy_c     = (state != ST_IDLE);
  assign wr_c       = C_WR && hit_c && !busy_c;
  assign wr_ctrl_c  = wr_c && (idx_c == REG_CTRL);
  assign start_c    = wr_ctrl_c && C_DATAO[CTRL_START];
  assign clr_acc_c  = wr_ctrl_c && C_DATAO[CTRL_CLR_ACC];
  assign clr_done_c = wr_ctrl_c && C_DATAO[CTRL_CLR_DONE];
  assign elem_inc_c = elem + LEN_W'(1);

  cim_mac_unit u_mac (
    .acc   (acc),
    .a     (a_q),
    .b     (M_DATAI[OPND_W-1:0]),
    .sum_c (mac_sum_c)
  );

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_c) state_nxt = (len == '0) ? ST_FIN : ST_FETCH_A;
      ST_FETCH_A: state_nxt = ST_FETCH_B;
      ST_FETCH_B: state_nxt = ST_ACC;
      ST_ACC:     state_nxt = (elem_inc_c == len) ? ST_FIN : ST_FETCH_A;
      ST_FIN:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Register file, element index, operand latch, accumulator and status
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      srca <= '0;
      srcb <= '0;
      len  <= '0;
      acc  <= '0;
      cyc  <= '0;
      elem <= '0;
      a_q  <= '0;
      done <= 1'b0;
    end else begin
      if (wr_c && idx_c == REG_SRCA) srca <= C_DATAO;
      if (wr_c && idx_c == REG_SRCB) srcb <= C_DATAO;
      if (wr_c && idx_c == REG_LEN)  len  <= C_DATAO[LEN_W-1:0];

      if (start_c)     cyc <= '0;
      else if (busy_c) cyc <= cyc + XLEN'(1);

      if (start_c)              elem <= '0;
      else if (state == ST_ACC) elem <= elem_inc_c;

      if (state == ST_FETCH_B) a_q <= M_DATAI[OPND_W-1:0];

      if (clr_acc_c)            acc <= '0;
      else if (state == ST_ACC) acc <= mac_sum_c;

      if (state == ST_FIN)             done <= 1'b1;
      else if (start_c || clr_done_c)  done <= 1'b0;
    end
  end

  assign DONE  = done;
  assign C_HLT = busy_c && (C_RD || C_WR) && !hit_c;

  always_comb begin
    rdata_c = '0;
    case (idx_c)
      REG_CTRL: rdata_c = {30'd0, done, busy_c};
      REG_SRCA: rdata_c = srca;
      REG_SRCB: rdata_c = srcb;
      REG_LEN:  rdata_c = 32'(len);
      REG_ACC:  rdata_c = acc;
      REG_CYC:  rdata_c = cyc;
      default:  rdata_c = '0;
    endcase
  end

  assign C_DATAI = hit_c ? rdata_c : M_DATAI;

  // Master port: core passthrough when idle, read-only FSM fetches when busy
  always_comb begin
    M_DADDR = C_DADDR;
    M_DATAO = C_DATAO;
    M_BE    = C_BE;
    M_RD    = C_RD && !hit_c;
    M_WR    = C_WR && !hit_c;
    if (busy_c) begin
      M_DADDR = '0;
      M_DATAO = '0;
      M_BE    = '0;
      M_RD    = 1'b0;
      M_WR    = 1'b0;
      if (state == ST_FETCH_A) begin
        M_DADDR = srca + 32'(elem);
        M_BE    = 4'hF;
        M_RD    = 1'b1;
      end else if (state == ST_FETCH_B) begin
        M_DADDR = srcb + 32'(elem);
        M_BE    = 4'hF;
        M_RD    = 1'b1;
      end
    end
  end

endmodule

// File: doc/cim_mac_seq.md
CIM_MAC_SEQ -- requirements
Module: cim_mac_seq

Interface
REQ-001 SHALL have parameter CIM_BASE, default 32'h08000000, byte base address of the CIM register window.
REQ-002 SHALL have parameter LEN_W, default 16, width of the element-count register.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port RES  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port C_DADDR  input  32  core word address (byte address >>2).
REQ-006 SHALL have ports C_DATAO input 32 (core write data), C_BE input 4, C_WR input 1, C_RD input 1.
REQ-007 SHALL have port C_DATAI  output  32  read data returned to core, same cycle as C_RD.
REQ-008 SHALL have port C_HLT  output  1  core stall request.
REQ-009 SHALL have ports M_DADDR output 32, M_DATAO output 32, M_BE output 4, M_WR output 1, M_RD output 1, M_DATAI input 32 (data memory master side).
REQ-010 SHALL have port DONE  output  1  sticky completion flag.

Function
REQ-011 SHALL decode a CIM hit when C_DADDR[31:3] == CIM_BASE[31:5]; register index = C_DADDR[2:0].
REQ-012 SHALL implement registers: 0 CTRL (W bit0 start, bit1 clear ACC, bit2 clear DONE; R bit0 busy, bit1 DONE), 1 SRCA, 2 SRCB (word addresses), 3 LEN, 4 ACC (read-only), 5 CYC (read-only busy-cycle counter); indices 6-7 read 0, writes ignored.
REQ-013 SHALL return CIM register read data combinationally on C_DATAI; writes take effect at the clock edge with C_WR=1, C_BE ignored.
REQ-014 SHALL pass core non-CIM accesses straight to M_* (address, data, BE, RD, WR; C_DATAI=M_DATAI) while FSM is IDLE.
REQ-015 SHALL run FSM IDLE -> FETCH_A -> FETCH_B -> ACC -> (FETCH_A if elements remain, else FIN) -> IDLE.
REQ-016 SHALL leave IDLE on CTRL write with bit0=1; if LEN==0, go to FIN directly with ACC unchanged.
REQ-017 SHALL issue M_RD=1, M_DADDR=SRCA+i in FETCH_A; latch M_DATAI as A and issue M_RD=1, M_DADDR=SRCB+i in FETCH_B; latch B and accumulate in ACC (one-cycle memory read latency).
REQ-018 SHALL accumulate ACC <= ACC + sext32(A[15:0] * B[15:0]) (signed 16x16), 32-bit wrap-around, no saturation.
REQ-019 SHALL take exactly 3*LEN+1 cycles from start edge to FIN for LEN>0; DONE set in FIN, FSM back to IDLE next cycle.
REQ-020 SHALL increment CYC every cycle FSM is not IDLE; cleared on start.
REQ-021 SHALL assert C_HLT combinationally when FSM is not IDLE and the core asserts C_RD or C_WR to a non-CIM address; M_* driven only by the FSM then.
REQ-022 SHALL allow core CIM register reads while busy (no stall); writes to SRCA/SRCB/LEN and start while busy are ignored.
REQ-023 SHALL clear DONE on start or CTRL bit2; if clear-ACC and start are written together, ACC clears first then accumulation starts from 0.
REQ-024 SHALL never assert M_WR from the FSM.

Reset
REQ-025 SHALL on RES=0 force FSM IDLE, SRCA=SRCB=LEN=ACC=CYC=0, DONE=0, C_HLT=0; mid-operation reset aborts with no further memory reads.
REQ-026 SHALL hold outputs M_RD=M_WR=0 during reset unless core passthrough drives them.

Structure
REQ-027 SHALL place CIM_BASE, register index constants, and FSM state encoding in shared package cim_pkg.
REQ-028 SHALL instantiate one sub-module cim_mac_unit (signed 16x16 multiply plus 32-bit accumulate).

Verification
REQ-029 SHALL cover: SRCA=0x100, SRCB=0x200, LEN=3, mem A={1,2,3}, B={4,5,6}, start -> DONE after 10 cycles, ACC=32, CYC=10.
REQ-030 SHALL cover: A=0x0000FFFF (-1), B=0x00000002, LEN=1 -> ACC=0xFFFFFFFE.
REQ-031 SHALL cover: LEN=0, start -> no M_RD, DONE=1 next cycle, ACC unchanged.
REQ-032 SHALL cover: core lw to main memory during busy -> C_HLT=1 until IDLE, then access completes with correct data.
REQ-033 SHALL cover: write LEN=9 and start during busy -> ignored, LEN and run unaffected; CTRL read shows busy=1.
REQ-034 SHALL cover: RES=0 in FETCH_B of LEN=4 run -> FSM IDLE, ACC=0, DONE=0, M_RD=0 immediately.
